// File: rtl/band_speed_ticker.sv
// band_speed_ticker
//
// Purpose:
//   Maps a track position (contador) to one of NBANDS bands and registers the
//   band index and that band's speed bit. The registered speed bit selects a
//   tick period. A free-running counter turns that period into a one-cycle
//   move-enable pulse (tick) for the object-motion logic.
//
// Build option:
//   BAND_SPEED_ACCEL_EN  When defined, period ramps toward its target by
//                        ACC_STEP on each tick edge, clamped at the target.
//                        When undefined, period follows the target directly.
//
// Ports:
//   clk       in   1               system clock, posedge
//   reset     in   1               synchronous, active-high, beats en
//   en        in   1               tick counter run enable
//   contador  in   POS_W           current position
//   v         in   NBANDS          speed bit per band (v[i] -> band i)
//   band      out  $clog2(NBANDS)  registered band index
//   out       out  1               registered selected speed bit
//   period    out  DIV_W           current tick period in cycles
//   tick      out  1               one-cycle move-enable pulse
module band_speed_ticker #(
    parameter int unsigned                   POS_W    = 9,
    parameter int unsigned                   NBANDS   = 3,
    parameter logic [(NBANDS-1)*POS_W-1:0]   BAND_TH  = {9'd350, 9'd250},
    parameter int unsigned                   DIV_W    = 24,
    parameter logic [DIV_W-1:0]              DIV_FAST = 24'd500_000,
    parameter logic [DIV_W-1:0]              DIV_SLOW = 24'd2_000_000,
    parameter logic [DIV_W-1:0]              ACC_STEP = 24'd100_000,
    localparam int unsigned                  BAND_W   = $clog2(NBANDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [POS_W-1:0]  contador,
    input  logic [NBANDS-1:0] v,
    output logic [BAND_W-1:0] band,
    output logic              out,
    output logic [DIV_W-1:0]  period,
    output logic              tick
);

    logic [BAND_W-1:0] band_d, band_q;
    logic              out_d, out_q;
    logic [DIV_W-1:0]  period_d, period_q;
    logic [DIV_W-1:0]  cnt_d, cnt_q;
    logic              tick_d, tick_q;
    logic [DIV_W-1:0]  target;

    // Bounds are strictly ascending, so the last bound passed is the highest
    // matching band; a position equal to a bound lands in the upper band.
    always_comb begin
        band_d = '0;
        out_d  = v[0];
        for (int unsigned i = 1; i < NBANDS; i++) begin
            if (contador >= BAND_TH[(i-1)*POS_W +: POS_W]) begin
                band_d = BAND_W'(i);
                out_d  = v[i];
            end
        end
    end

    assign target = out_q ? DIV_FAST : DIV_SLOW;

    // Compare with >= so a period that shrinks below the running count
    // fires on the next edge instead of running the counter to wrap-around.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en) begin
            if (cnt_q >= period_q - DIV_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

`ifdef BAND_SPEED_ACCEL_EN
    // Step toward the target only on tick edges; the distance test before
    // adding/subtracting keeps the step from overshooting or underflowing.
    always_comb begin
        period_d = period_q;
        if (tick_d) begin
            if (period_q < target) begin
                period_d = (target - period_q > ACC_STEP) ? period_q + ACC_STEP : target;
            end else if (period_q > target) begin
                period_d = (period_q - target > ACC_STEP) ? period_q - ACC_STEP : target;
            end
        end
    end
`else
    always_comb begin
        period_d = target;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            band_q   <= '0;
            out_q    <= 1'b0;
            period_q <= DIV_SLOW;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            band_q   <= band_d;
            out_q    <= out_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

    assign band   = band_q;
    assign out    = out_q;
    assign period = period_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_band_speed_ticker.sv
// Directed bench for band_speed_ticker using small periods
// (DIV_FAST=4, DIV_SLOW=10, ACC_STEP=2).
module tb_band_speed_ticker;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [8:0]  contador;
    logic [2:0]  v;
    logic [1:0]  band;
    logic        out;
    logic [23:0] period;
    logic        tick;

    int compared   = 0;
    int mismatched = 0;

    band_speed_ticker #(
        .POS_W    (9),
        .NBANDS   (3),
        .BAND_TH  ({9'd350, 9'd250}),
        .DIV_W    (24),
        .DIV_FAST (24'd4),
        .DIV_SLOW (24'd10),
        .ACC_STEP (24'd2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .contador (contador),
        .v        (v),
        .band     (band),
        .out      (out),
        .period   (period),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges until tick is seen, or -1 if the budget runs out.
    task automatic wait_tick(input int max_edges, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= max_edges; i++) begin
            if (!found) begin
                step();
                if (tick === 1'b1) begin
                    found = 1'b1;
                    n = i;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int seen;

        reset    = 1'b1;
        en       = 1'b0;
        contador = 9'd0;
        v        = 3'b000;
        step();
        chk("rst_band", 32'(band), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_period", 32'(period), 32'd10);
        chk("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;

        // Just below and at the lower bound of band 1.
        contador = 9'd249;
        v        = 3'b001;
        step();
        chk("b249_band", 32'(band), 32'd0);
        chk("b249_out", 32'(out), 32'd1);
`ifndef BAND_SPEED_ACCEL_EN
        chk("period_lag", 32'(period), 32'd10);
`endif
        contador = 9'd250;
        step();
        chk("b250_band", 32'(band), 32'd1);
        chk("b250_out", 32'(out), 32'd0);
`ifndef BAND_SPEED_ACCEL_EN
        chk("period_fast", 32'(period), 32'd4);
`endif

        // Top band boundary and maximum position.
        v        = 3'b100;
        contador = 9'd349;
        step();
        chk("b349_band", 32'(band), 32'd1);
        chk("b349_out", 32'(out), 32'd0);
        contador = 9'd350;
        step();
        chk("b350_band", 32'(band), 32'd2);
        chk("b350_out", 32'(out), 32'd1);
        contador = 9'd511;
        step();
        chk("b511_band", 32'(band), 32'd2);
        chk("b511_out", 32'(out), 32'd1);

`ifndef BAND_SPEED_ACCEL_EN
        // Fast period, steady: let period settle with en low, then run.
        contador = 9'd0;
        v        = 3'b001;
        do_reset();
        step();
        step();
        step();
        chk("fast_period", 32'(period), 32'd4);
        en = 1'b1;
        wait_tick(20, n);
        chk("fast_first", 32'(n), 32'd4);
        step();
        chk("tick_single", 32'(tick), 32'd0);
        wait_tick(20, n);
        chk("fast_gap_a", 32'(n), 32'd3);
        wait_tick(20, n);
        chk("fast_gap_b", 32'(n), 32'd4);

        // Slow period with a 5-cycle pause after 3 counts.
        en = 1'b0;
        v  = 3'b000;
        do_reset();
        en = 1'b1;
        wait_tick(30, n);
        chk("slow_first", 32'(n), 32'd10);
        step();
        step();
        step();
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (tick === 1'b1) seen++;
        end
        chk("pause_ticks", 32'(seen), 32'd0);
        en = 1'b1;
        wait_tick(30, n);
        chk("pause_gap", 32'(n + 8), 32'd15);
        wait_tick(30, n);
        chk("resume_gap", 32'(n), 32'd10);

        // Period shrinks below the running count: tick on the next edge.
        for (int i = 0; i < 7; i++) step();
        v = 3'b001;
        wait_tick(30, n);
        chk("shrink_tick", 32'(n), 32'd3);
        wait_tick(30, n);
        chk("shrink_gap", 32'(n), 32'd4);

        // Reset mid-count with en still high.
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_band", 32'(band), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_period", 32'(period), 32'd10);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        wait_tick(30, n);
        chk("post_rst_tick", 32'(n), 32'd4);
`else
        // Ramp down 10 -> 4 on successive ticks, then back up.
        contador = 9'd0;
        v        = 3'b001;
        en       = 1'b1;
        do_reset();
        wait_tick(30, n);
        chk("ramp_gap0", 32'(n), 32'd10);
        chk("ramp_per0", 32'(period), 32'd8);
        wait_tick(30, n);
        chk("ramp_gap1", 32'(n), 32'd8);
        chk("ramp_per1", 32'(period), 32'd6);
        wait_tick(30, n);
        chk("ramp_gap2", 32'(n), 32'd6);
        chk("ramp_per2", 32'(period), 32'd4);
        wait_tick(30, n);
        chk("ramp_gap3", 32'(n), 32'd4);
        chk("ramp_per3", 32'(period), 32'd4);
        v = 3'b000;
        wait_tick(30, n);
        chk("up_gap0", 32'(n), 32'd4);
        chk("up_per0", 32'(period), 32'd6);
        wait_tick(30, n);
        chk("up_gap1", 32'(n), 32'd6);
        chk("up_per1", 32'(period), 32'd8);
        wait_tick(30, n);
        chk("up_gap2", 32'(n), 32'd8);
        chk("up_per2", 32'(period), 32'd10);
        wait_tick(30, n);
        chk("up_gap3", 32'(n), 32'd10);
        chk("up_per3", 32'(period), 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
